// File: rtl/tw4_sequencer_pkg.sv
// Shared TW4 types: instruction encoding and sequencer state.
package tw4_sequencer_pkg;

   typedef enum logic [3:0] {
      OP_ADD_A_IMM = 4'b0000,
      OP_MOV_A_B   = 4'b0001,
      OP_IN_A      = 4'b0010,
      OP_MOV_A_IMM = 4'b0011,
      OP_MOV_B_A   = 4'b0100,
      OP_ADD_B_IMM = 4'b0101,
      OP_IN_B      = 4'b0110,
      OP_MOV_B_IMM = 4'b0111,
      OP_OUT_B     = 4'b1001,
      OP_OUT_IMM   = 4'b1011,
      OP_JNC       = 4'b1110,
      OP_JMP       = 4'b1111
   } opcode_t;

   typedef struct packed {
      opcode_t    op;
      logic [3:0] imm;
   } instr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_FAULT
   } seq_state_t;

   // Only the two adds produce a carry; every other opcode clears it.
   function automatic logic is_carry_op(input opcode_t op);
      return (op == OP_ADD_A_IMM) || (op == OP_ADD_B_IMM);
   endfunction

endpackage

// File: rtl/tw4_fetch_watchdog.sv
// Counts fetch cycles without an acknowledge; flags the cycle that reaches TIMEOUT.
module tw4_fetch_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The current unacknowledged cycle is the TIMEOUT-th one.
   assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/tw4_sequencer.sv
// TW4 instruction sequencer: PC/carry ownership, fetch handshake, execute enable, run/step/breakpoint.
module tw4_sequencer
   import tw4_sequencer_pkg::*;
#(
   parameter logic [3:0] RESET_PC = 4'h0,
   parameter int         TIMEOUT  = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic       step,
   input  logic       bp_en,
   input  logic [3:0] bp_addr,
   output logic       mem_req,
   output logic [3:0] mem_addr,
   input  logic       mem_ack,
   input  logic [7:0] mem_data,
   output logic [7:0] instr,
   output logic       exec_en,
   input  logic       alu_carry,
   output logic [3:0] pc,
   output logic       carry,
   output logic       halted,
   output logic       fault
);

   seq_state_t state_q, state_d;
   logic [3:0] pc_q, pc_d, pc_next;
   logic       carry_q, carry_d;
   instr_t     instr_q, instr_d;
   logic       mem_req_q, mem_req_d;
   logic       exec_en_q, exec_en_d;
   logic       halted_q, halted_d;
   logic       fault_q, fault_d;
   logic       wd_expired;

   tw4_fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clr     (state_q != ST_FETCH),
      .en      ((state_q == ST_FETCH) && !mem_ack),
      .expired (wd_expired)
   );

   // JNC tests the carry held before this instruction updates it.
   always_comb begin
      case (instr_q.op)
         OP_JMP:  pc_next = instr_q.imm;
         OP_JNC:  pc_next = carry_q ? (pc_q + 4'd1) : instr_q.imm;
         default: pc_next = pc_q + 4'd1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      carry_d = carry_q;
      instr_d = instr_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (run || step) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ack) begin
               instr_d = instr_t'(mem_data);
               state_d = ST_EXEC;
            end else if (wd_expired) begin
               fault_d = 1'b1;
               state_d = ST_FAULT;
            end
         end
         ST_EXEC: begin
            pc_d    = pc_next;
            carry_d = is_carry_op(instr_q.op) ? alu_carry : 1'b0;
            state_d = (run && !(bp_en && (pc_next == bp_addr))) ? ST_FETCH : ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: state_d = ST_IDLE;
      endcase
      // Outputs are decoded from the next state so they are registered alongside it.
      mem_req_d = (state_d == ST_FETCH);
      exec_en_d = (state_d == ST_EXEC);
      halted_d  = (state_d == ST_IDLE) || (state_d == ST_FAULT);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         carry_q   <= 1'b0;
         instr_q   <= '0;
         mem_req_q <= 1'b0;
         exec_en_q <= 1'b0;
         halted_q  <= 1'b1;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         carry_q   <= carry_d;
         instr_q   <= instr_d;
         mem_req_q <= mem_req_d;
         exec_en_q <= exec_en_d;
         halted_q  <= halted_d;
         fault_q   <= fault_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = pc_q;
   assign instr    = instr_q;
   assign exec_en  = exec_en_q;
   assign pc       = pc_q;
   assign carry    = carry_q;
   assign halted   = halted_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_tw4_sequencer.sv
// Scoreboard bench for tw4_sequencer: ISA-level model fed by a ROM responder, checked by an exec monitor.
module tb_tw4_sequencer;

   localparam logic [3:0] RST_PC = 4'h5;
   localparam int         TMO    = 4;
   localparam logic [3:0] ADD_A = 4'h0, MOV_A = 4'h3, ADD_B = 4'h5, JNC = 4'hE, JMP = 4'hF;
   localparam int AM_NORMAL = 0, AM_NONE = 1, AM_LEVEL = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0, step = 1'b0, bp_en = 1'b0;
   logic [3:0] bp_addr = 4'h0;
   logic       mem_req, exec_en, carry, halted, fault;
   logic [3:0] mem_addr, pc;
   logic       mem_ack = 1'b0, alu_carry = 1'b0;
   logic [7:0] mem_data = 8'h00, instr;

   typedef struct {
      logic [3:0] pc;
      logic [7:0] instr;
      logic [3:0] npc;
      logic       ncarry;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rom [16];
   int         n_chk = 0, n_pass = 0;
   int         ack_mode = AM_NORMAL, fixed_lat = -1, carry_mode = 2;
   logic [3:0] model_pc = RST_PC;
   logic       model_carry = 1'b0;
   logic [7:0] last_instr = 8'h00;
   bit         waiting = 0;
   int         wait_left = 0;
   int         exec_cnt = 0, cyc = 0;
   int         exec_times[$];
   bit         post_pending = 0, post_halt = 0;
   exp_t       post, r_e, m_e;
   logic [3:0] r_op;
   logic       r_c;

   tw4_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .run(run), .step(step), .bp_en(bp_en), .bp_addr(bp_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .instr(instr), .exec_en(exec_en), .alu_carry(alu_carry), .pc(pc), .carry(carry),
      .halted(halted), .fault(fault)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ROM responder: acknowledges fetches and advances the instruction-level model.
   always @(posedge clock) begin
      #2;
      mem_ack = 1'b0;
      if (!reset) begin
         model_pc = RST_PC; model_carry = 1'b0; last_instr = 8'h00;
         waiting = 0; exp_q.delete();
      end else if (ack_mode == AM_LEVEL) begin
         mem_ack = 1'b1; mem_data = 8'($urandom);
      end else if (ack_mode == AM_NORMAL && mem_req) begin
         if (!waiting) begin
            waiting = 1;
            wait_left = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 2);
         end
         if (wait_left == 0) begin
            check("fetch_addr", mem_addr, model_pc);
            r_c = (carry_mode == 2) ? 1'($urandom_range(0, 1)) : (carry_mode == 1);
            r_e.pc = model_pc; r_e.instr = rom[model_pc]; r_op = r_e.instr[7:4];
            if (r_op == JMP || (r_op == JNC && !model_carry)) r_e.npc = r_e.instr[3:0];
            else r_e.npc = model_pc + 4'd1;
            r_e.ncarry = (r_op == ADD_A || r_op == ADD_B) ? r_c : 1'b0;
            mem_data = r_e.instr; mem_ack = 1'b1; alu_carry = r_c; waiting = 0;
            exp_q.push_back(r_e);
            model_pc = r_e.npc; model_carry = r_e.ncarry; last_instr = r_e.instr;
         end else begin
            wait_left--;
         end
      end
   end

   // Monitor: every exec pulse must match the next expected instruction.
   always @(negedge clock) begin
      cyc++;
      if (post_pending) begin
         post_pending = 0;
         check("post_pc", pc, post.npc);
         check("post_carry", carry, post.ncarry);
         check("post_halted", halted, post_halt);
      end
      if (reset && exec_en) begin
         exec_cnt++;
         exec_times.push_back(cyc);
         check("exec_no_req", mem_req, 0);
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL exec_unexpected: exec_en with empty queue, pc %0h", pc);
         end else begin
            m_e = exp_q.pop_front();
            check("exec_pc", pc, m_e.pc);
            check("exec_instr", instr, m_e.instr);
            post = m_e;
            post_halt = !(run && !(bp_en && (m_e.npc == bp_addr)));
            post_pending = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic wait_exec(input int target, input int max, input string name);
      int k = 0;
      while (exec_cnt < target && k < max) begin tick(); k++; end
      n_chk++;
      if (exec_cnt >= target) n_pass++;
      else $display("FAIL %s: exec count %0d, required %0d", name, exec_cnt, target);
   endtask

   task automatic wait_halt(input int max, input string name);
      int k = 0;
      while (!(halted && exp_q.size() == 0 && !post_pending) && k < max) begin tick(); k++; end
      check(name, halted, 1);
   endtask

   task automatic wait_req(input int max, input string name);
      int k = 0;
      while (!mem_req && k < max) begin tick(); k++; end
      check(name, mem_req, 1);
   endtask

   task automatic do_step(input bit twice);
      int start = exec_cnt;
      step = 1'b1; tick(); step = 1'b0;
      if (twice) begin tick(); step = 1'b1; tick(); step = 1'b0; end
      repeat (10) tick();
      @(negedge clock);
      check("step_once", exec_cnt - start, 1);
      check("step_halted", halted, 1);
      tick();
   endtask

   initial begin
      int         start, n;
      logic [3:0] p, pn;
      for (int i = 0; i < 16; i++) rom[i] = {MOV_A, 4'($urandom)};

      repeat (3) tick();
      @(negedge clock);
      check("rst_pc", pc, RST_PC);
      check("rst_carry", carry, 0);
      check("rst_instr", instr, 0);
      check("rst_exec_en", exec_en, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_halted", halted, 1);
      check("rst_fault", fault, 0);
      tick();
      reset = 1'b1;

      // Free run over a MOV-only program with zero-wait memory.
      fixed_lat = 0; carry_mode = 2; start = exec_cnt; run = 1'b1;
      wait_exec(start + 17, 60, "mov_run");
      if (exec_times.size() >= start + 17)
         check("mov_period", exec_times[start + 16] - exec_times[start], 32);
      run = 1'b0;
      wait_halt(20, "mov_stop");

      // Single-step ADD then JNC, carry set then clear.
      fixed_lat = 2;
      p = model_pc; pn = p + 4'd1;
      rom[p] = {ADD_A, 4'($urandom)}; rom[pn] = {JNC, 4'h9}; carry_mode = 1;
      do_step(1);
      check("add_carry_set", carry, 1);
      do_step(0);
      check("jnc_not_taken", pc, p + 4'd2);
      p = model_pc; pn = p + 4'd1;
      rom[p] = {ADD_B, 4'($urandom)}; rom[pn] = {JNC, 4'h9}; carry_mode = 0;
      do_step(0);
      check("add_carry_clr", carry, 0);
      do_step(0);
      check("jnc_taken", pc, 4'h9);

      // Breakpoint on a jump target while running.
      p = model_pc; rom[p] = {JMP, 4'hA};
      bp_en = 1'b1; bp_addr = 4'hA; fixed_lat = 0; carry_mode = 2;
      start = exec_cnt; run = 1'b1;
      wait_exec(start + 1, 10, "bp_jmp");
      @(negedge clock);
      check("bp_halted", halted, 1);
      check("bp_no_req", mem_req, 0);
      check("bp_pc", pc, 4'hA);
      tick();
      @(negedge clock);
      check("bp_resume_req", mem_req, 1);
      check("bp_resume_addr", mem_addr, 4'hA);
      tick();
      run = 1'b0; bp_en = 1'b0;
      wait_halt(20, "bp_stop");

      // Random program, random latency, random run/step/breakpoint traffic.
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      fixed_lat = -1; start = exec_cnt; run = 1'b1;
      repeat (400) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         step = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) begin
            bp_en = 1'($urandom); bp_addr = 4'($urandom);
         end
         tick();
      end
      run = 1'b0; step = 1'b0; bp_en = 1'b0;
      wait_halt(30, "rand_stop");
      check("rand_progress", exec_cnt > start + 20, 1);

      // Fetch timeout and sticky fault.
      ack_mode = AM_NONE; run = 1'b1;
      wait_req(10, "tmo_req_start");
      n = 0;
      while (mem_req && n < 20) begin n++; tick(); end
      check("tmo_req_cycles", n, TMO);
      @(negedge clock);
      check("tmo_fault", fault, 1);
      check("tmo_halted", halted, 1);
      check("tmo_req_low", mem_req, 0);
      tick();
      ack_mode = AM_LEVEL; start = exec_cnt;
      repeat (3) begin step = 1'b1; tick(); step = 1'b0; tick(); end
      repeat (4) tick();
      @(negedge clock);
      check("fault_sticky", fault, 1);
      check("fault_halted", halted, 1);
      check("fault_no_req", mem_req, 0);
      check("fault_pc_frozen", pc, model_pc);
      check("fault_instr_frozen", instr, last_instr);
      check("fault_no_exec", exec_cnt - start, 0);
      tick();
      ack_mode = AM_NORMAL; reset = 1'b0; run = 1'b0;
      tick();
      @(negedge clock);
      check("fault_rst_fault", fault, 0);
      check("fault_rst_pc", pc, RST_PC);
      check("fault_rst_halted", halted, 1);
      tick();
      reset = 1'b1;

      // Reset in the middle of a slow fetch.
      fixed_lat = 3; run = 1'b1;
      wait_req(10, "mid_req_start");
      tick();
      reset = 1'b0; run = 1'b0;
      tick();
      @(negedge clock);
      check("mid_rst_req", mem_req, 0);
      check("mid_rst_exec", exec_en, 0);
      check("mid_rst_pc", pc, RST_PC);
      check("mid_rst_carry", carry, 0);
      check("mid_rst_instr", instr, 0);
      check("mid_rst_halted", halted, 1);
      check("mid_rst_fault", fault, 0);
      tick();
      reset = 1'b1; ack_mode = AM_LEVEL; start = exec_cnt;
      repeat (5) tick();
      @(negedge clock);
      check("late_ack_req", mem_req, 0);
      check("late_ack_instr", instr, 0);
      check("late_ack_halted", halted, 1);
      check("late_ack_exec", exec_cnt - start, 0);
      tick();
      ack_mode = AM_NORMAL;

      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tw4_sequencer.md
Name: tw4_sequencer

Overview:
Instruction-sequencing controller for the TW4 4-bit core. It owns the program counter and carry flag, fetches 8-bit instructions from program memory over a req/ack handshake, and issues one-cycle execute enables to the core. Resolves JMP/JNC and provides run/halt/single-step/breakpoint control. Sits between program ROM and the core datapath.

Parameters:
RESET_PC, 4'h0, PC value loaded on reset
TIMEOUT, 15, max FETCH cycles without mem_ack before fault (1..255)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
run  input  1  level; free-run while high
step  input  1  one-cycle pulse; execute exactly one instruction while halted
bp_en  input  1  breakpoint enable
bp_addr  input  4  breakpoint PC
mem_req  output  1  fetch request, held until mem_ack
mem_addr  output  4  fetch address (= pc)
mem_ack  input  1  memory data valid
mem_data  input  8  {opcode[7:4], imm[3:0]}
instr  output  8  latched current instruction
exec_en  output  1  one-cycle core execute enable
alu_carry  input  1  core adder carry-out, valid while exec_en=1
pc  output  4  program counter
carry  output  1  carry flag
halted  output  1  high in IDLE or FAULT
fault  output  1  sticky fetch-timeout flag

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, pc=RESET_PC, carry=0, instr=0, exec_en=0, mem_req=0, halted=1, fault=0, watchdog=0. Overrides everything, including mid-fetch; mem_req is low after that edge.
- States: IDLE, FETCH, EXEC, FAULT.
- IDLE: if run=1 or step=1, go to FETCH. The breakpoint is not checked on leaving IDLE, so run resumes from a breakpoint PC.
- FETCH: mem_req=1, mem_addr=pc.
  - mem_ack=1: latch instr<=mem_data, go to EXEC. Zero-wait ack in the first FETCH cycle is legal, so minimum instruction period is 2 cycles.
  - mem_ack outside FETCH is ignored.
- EXEC: exec_en=1 for exactly this cycle. At the end of the cycle:
  - PC: JMP (4'b1111): pc<=imm. JNC (4'b1110): pc<=imm if carry==0, else pc+1. Otherwise pc<=pc+1, wrapping 4'hF to 4'h0.
  - Carry: carry<=alu_carry for ADD_A_IMM (4'b0000) and ADD_B_IMM (4'b0101); carry<=0 for all other opcodes, including jumps. JNC tests the carry value held before this update.
  - Next state: FETCH if run=1 and not (bp_en=1 and next pc==bp_addr); otherwise IDLE.
  - An instruction started by step always returns to IDLE unless run=1.
- step while not in IDLE is ignored; it is not queued.
- Watchdog:
  - Counts FETCH cycles without ack; cleared on entering FETCH.
  - When the count reaches TIMEOUT: go to FAULT, mem_req=0, fault=1.
  - FAULT is exited only by reset. pc and instr are frozen at the faulting fetch.
- run deasserted mid-FETCH: the fetch and execute still complete, then the sequencer goes to IDLE.
- halted = (state==IDLE or state==FAULT), registered.

Decomposition:
- The shared types header already holds opcode_t and the instruction struct; reuse them for decode.
- Add seq_state_t (IDLE/FETCH/EXEC/FAULT) to the same package.
- One sub-module: tw4_fetch_watchdog (TIMEOUT-parameterised counter with clear/enable, expired output).

Test Plan:
- Reset, run=1, ROM always acks in 1 cycle, program of 16 MOV_A_IMM → pc sequence 0,1,…,F,0. exec_en pulses every 2 cycles. carry stays 0.
- ADD_A_IMM with alu_carry=1 at pc=3, JNC 4'h9 at pc=4 → carry=1 after pc=3, JNC not taken, pc=5. Repeat with alu_carry=0 → pc=9 and carry=0.
- JMP 4'hA with bp_en=1, bp_addr=4'hA, run=1 → halted=1 with pc=A and no fetch issued. Pulsing run keeps it high, then fetch from A proceeds.
- Halted at pc=2, step pulse → exactly one mem_req/exec_en, pc=3, halted=1. A step pulsed during that FETCH produces no second instruction.
- TIMEOUT=4, mem_ack held 0 → mem_req high 4 cycles then low, fault=1, halted=1. Later mem_ack, run and step have no effect. reset=0 clears fault and sets pc=RESET_PC.
- reset=0 asserted while in FETCH with a 3-cycle ack latency → mem_req=0 next cycle and all outputs at reset values. The late ack is ignored.
